// File: rtl/addsub_pipe_n.sv
// addsub_pipe_n: pipelined add / sub / rsub / unsigned absolute-difference unit.
// The carry chain is split into STAGES registered chunks, followed by one
// correction/flag stage. Valid/ready on both sides; the whole pipe freezes
// when the output is stalled. A sideband tag rides along with each operation.
// Optional build macro: ADDSUB_SATURATE_EN adds the in_sat port and signed
// saturation for add/sub/rsub.
module addsub_pipe_n #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
`ifdef ADDSUB_SATURATE_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags
);

  localparam int CW = WIDTH / STAGES;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_RSUB = 2'b10;
  localparam logic [1:0] OP_ABS  = 2'b11;

  // One carry chunk: CW-bit add with carry in, carry out in the MSB.
  function automatic logic [CW:0] chunk_add(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b,
                                            input logic          cin);
    return {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
  endfunction

  // Signed saturation bound: positive overflow clamps to max, negative to min.
  function automatic logic signed [WIDTH-1:0] sat_clamp(input logic pos_ovf);
    return pos_ovf ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
  endfunction

  logic                     advance;
  logic                     sat_acc;
  logic [WIDTH-1:0]         a_prep, b_prep;
  logic                     cin;
  logic [CW:0]              chunk_s;

  logic [STAGES-1:0]        vld_q, c_q, c_d, sat_q;
  logic [WIDTH-1:0]         a_q   [STAGES];
  logic [WIDTH-1:0]         b_q   [STAGES];
  logic [WIDTH-1:0]         sum_q [STAGES];
  logic [WIDTH-1:0]         sum_d [STAGES];
  logic [1:0]               op_q  [STAGES];
  logic [TAG_W-1:0]         tag_q [STAGES];

  logic                     out_valid_q;
  logic [WIDTH-1:0]         out_res_q;
  logic [TAG_W-1:0]         out_tag_q;
  logic [3:0]               out_flags_q;

  logic [WIDTH-1:0]         raw;
  logic signed [WIDTH-1:0]  res_d;
  logic                     is_abs, fin_c, ovf;
  logic [3:0]               flags_d;

`ifdef ADDSUB_SATURATE_EN
  assign sat_acc = in_sat;
`else
  assign sat_acc = 1'b0;
`endif

  // A stalled output freezes the entire pipe; otherwise everything moves.
  assign advance   = out_ready | ~out_valid_q;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_tag   = out_tag_q;
  assign out_flags = out_flags_q;

  // Operand preparation: subtraction forms are A' + ~B' + 1.
  always_comb begin
    a_prep = in_a;
    b_prep = ~in_b;
    cin    = 1'b1;
    case (in_op)
      OP_ADD: begin
        b_prep = in_b;
        cin    = 1'b0;
      end
      OP_RSUB: begin
        a_prep = in_b;
        b_prep = ~in_a;
      end
      default: ;
    endcase
  end

  // Chunk adders: stage 0 sees prepared inputs, stage k sees stage k-1 registers.
  always_comb begin
    c_d = '0;
    for (int k = 0; k < STAGES; k++) sum_d[k] = '0;
    chunk_s = chunk_add(a_prep[CW-1:0], b_prep[CW-1:0], cin);
    c_d[0] = chunk_s[CW];
    sum_d[0][CW-1:0] = chunk_s[CW-1:0];
    for (int k = 1; k < STAGES; k++) begin
      chunk_s = chunk_add(a_q[k-1][k*CW +: CW], b_q[k-1][k*CW +: CW], c_q[k-1]);
      c_d[k] = chunk_s[CW];
      sum_d[k] = sum_q[k-1];
      sum_d[k][k*CW +: CW] = chunk_s[CW-1:0];
    end
  end

  // Carry stages _p0.._p(STAGES-1): capture on accept, then shift on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      c_q   <= '0;
      sat_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        op_q[k]  <= '0;
        tag_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        a_q[0]   <= a_prep;
        b_q[0]   <= b_prep;
        sum_q[0] <= sum_d[0];
        c_q[0]   <= c_d[0];
        op_q[0]  <= in_op;
        tag_q[0] <= in_tag;
        sat_q[0] <= sat_acc;
      end
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
        sum_q[k] <= sum_d[k];
        c_q[k]   <= c_d[k];
        op_q[k]  <= op_q[k-1];
        tag_q[k] <= tag_q[k-1];
        sat_q[k] <= sat_q[k-1];
      end
    end
  end

  // Correction and flags: absdiff negates a borrowed result, saturation clamps.
  always_comb begin
    raw    = sum_q[STAGES-1];
    fin_c  = c_q[STAGES-1];
    is_abs = (op_q[STAGES-1] == OP_ABS);
    ovf    = ~is_abs & (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &
             (raw[WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
    res_d  = (is_abs & ~fin_c) ? signed'((~raw) + 1'b1) : signed'(raw);
    if (sat_q[STAGES-1] & ovf) res_d = sat_clamp(raw[WIDTH-1]);
    flags_d = {(is_abs ? ~fin_c : res_d[WIDTH-1]), (res_d == '0), fin_c, ovf};
  end

  // Output stage: loads only real results so outputs hold across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_tag_q   <= '0;
      out_flags_q <= '0;
    end else if (advance) begin
      out_valid_q <= vld_q[STAGES-1];
      if (vld_q[STAGES-1]) begin
        out_res_q   <= res_d;
        out_tag_q   <= tag_q[STAGES-1];
        out_flags_q <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe_n.sv
// Bench for addsub_pipe_n: directed and randomized ops checked against an
// integer-arithmetic reference model; backpressure stream with a scoreboard.
`timescale 1ns/1ps
module tb_addsub_pipe_n;
  localparam int W  = 32;
  localparam int S  = 4;
  localparam int TW = 4;
  localparam longint SMAX = (64'sd1 <<< (W-1)) - 64'sd1;
  localparam longint SMIN = -(64'sd1 <<< (W-1));

  logic          clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_a, in_b, out_res;
  logic [1:0]    in_op;
  logic [TW-1:0] in_tag, out_tag;
  logic [3:0]    out_flags;
`ifdef ADDSUB_SATURATE_EN
  logic          in_sat;
`endif
  int total, bad;

  addsub_pipe_n #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
`ifdef ADDSUB_SATURATE_EN
    .in_sat(in_sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_tag(out_tag), .out_flags(out_flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer arithmetic; returns {res, N, Z, C, V}.
  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op, input logic sat);
    longint sa, sb, ua, ub, sres;
    logic [W-1:0] res;
    logic n, z, c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    sres = 0;
    case (op)
      2'd0: begin sres = sa + sb; res = a + b; c = (ua + ub) >= (64'sd1 <<< W); end
      2'd1: begin sres = sa - sb; res = a - b; c = (ua >= ub); end
      2'd2: begin sres = sb - sa; res = b - a; c = (ub >= ua); end
      default: begin res = (ua >= ub) ? a - b : b - a; c = (ua >= ub); end
    endcase
    v = (op != 2'd3) && ((sres > SMAX) || (sres < SMIN));
    if (sat && v) res = (sres > SMAX) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
    n = (op == 2'd3) ? !c : res[W-1];
    z = (res == '0);
    return {res, n, z, c, v};
  endfunction

  task automatic test_reset();
    int lat;
    logic [W+3:0] exp;
    rst = 1'b1; in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_op = 2'd0;
    in_tag = 4'hA; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_res, out_tag, out_flags} !== '0) begin
        bad++;
        $display("FAIL reset_state[%0d]: got v=%b res=%h tag=%h flags=%b want all zero",
                 i, out_valid, out_res, out_tag, out_flags);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_no_ghost[%0d]: got out_valid=%b want 0", i, out_valid);
      end
    end
    in_valid = 1'b1; in_a = 32'd5; in_b = 32'd7; in_op = 2'd0; in_tag = 4'd3;
    exp = {32'd12, 4'b0000};
    lat = 0;
    do begin
      @(negedge clk); in_valid = 1'b0; lat++;
    end while (!out_valid && lat < 20);
    total++;
    if (lat != S + 1 || {out_res, out_flags} !== exp || out_tag !== 4'd3) begin
      bad++;
      $display("FAIL reset_first_op: got lat=%0d res=%h flags=%b tag=%h want lat=%0d res=%h flags=%b tag=3",
               lat, out_res, out_flags, out_tag, S + 1, exp[W+3:4], exp[3:0]);
    end
  endtask

  task automatic test_add();
    logic [W-1:0] ta [2] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [W-1:0] tr [2] = '{32'h0000_0000, 32'h8000_0000};
    logic [3:0]   tf [2] = '{4'b0110, 4'b1001};
    logic [W-1:0] a, b;
    logic [TW-1:0] tag;
    logic [W+3:0] exp;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 2) begin
        a = ta[i]; b = 32'd1; exp = {tr[i], tf[i]}; tag = (i == 0) ? 4'd5 : 4'd9;
      end else begin
        a = $urandom; b = (i % 3 == 0) ? (~a + 32'd1) : $urandom; tag = TW'($urandom);
        exp = model(a, b, 2'd0, 1'b0);
      end
      @(negedge clk);
      in_valid = 1'b1; in_a = a; in_b = b; in_op = 2'd0; in_tag = tag;
      lat = 0;
      do begin
        @(negedge clk); in_valid = 1'b0; in_op = 2'd3; in_tag = '0; lat++;
      end while (!out_valid && lat < 20);
      total++;
      if (lat != S + 1) begin
        bad++; $display("FAIL add_latency[%0d]: got %0d want %0d", i, lat, S + 1);
      end
      total++;
      if ({out_res, out_flags} !== exp || out_tag !== tag) begin
        bad++;
        $display("FAIL add_result[%0d]: got res=%h flags=%b tag=%h want res=%h flags=%b tag=%h",
                 i, out_res, out_flags, out_tag, exp[W+3:4], exp[3:0], tag);
      end
    end
  endtask

  task automatic test_sub_modes();
    logic [W-1:0] ta [4] = '{32'd3, 32'd3, 32'd3, 32'd10};
    logic [W-1:0] tb [4] = '{32'd10, 32'd10, 32'd10, 32'd3};
    logic [1:0]   to [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic [W-1:0] tr [4] = '{32'hFFFF_FFF9, 32'd7, 32'd7, 32'd7};
    logic [3:0]   tf [4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
    logic [W-1:0] a, b;
    logic [1:0] op;
    logic [TW-1:0] tag;
    logic [W+3:0] exp;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < 4) begin
        a = ta[i]; b = tb[i]; op = to[i]; exp = {tr[i], tf[i]};
      end else begin
        op = 2'(i % 3 + 1);
        a = (i % 5 == 0) ? 32'(1 <<< (W-1)) : $urandom;
        b = (i % 4 == 0) ? a : ((i % 2) ? $urandom_range(0, 255) : $urandom);
        exp = model(a, b, op, 1'b0);
      end
      tag = TW'(i);
      @(negedge clk);
      in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_tag = tag;
      lat = 0;
      do begin
        @(negedge clk); in_valid = 1'b0; in_op = 2'd0; lat++;
      end while (!out_valid && lat < 20);
      total++;
      if (lat != S + 1 || {out_res, out_flags} !== exp || out_tag !== tag) begin
        bad++;
        $display("FAIL submode[%0d] op=%0d: got lat=%0d res=%h flags=%b tag=%h want lat=%0d res=%h flags=%b tag=%h",
                 i, op, lat, out_res, out_flags, out_tag, S + 1, exp[W+3:4], exp[3:0], tag);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W+3:0]  exp_q [$];
    logic [TW-1:0] tag_q [$];
    logic [W-1:0]  ca, cb, hold_res;
    logic [1:0]    cop;
    logic [TW-1:0] hold_tag;
    logic [3:0]    hold_flags;
    logic          stalled;
    logic [W+3:0]  exp;
    logic [TW-1:0] etag;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; stalled = 1'b0;
    hold_res = '0; hold_tag = '0; hold_flags = '0;
    ca = $urandom; cb = $urandom; cop = 2'($urandom_range(0, 3));
    while (got < 20 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        total++;
        if (out_valid !== 1'b1 || out_res !== hold_res || out_tag !== hold_tag ||
            out_flags !== hold_flags) begin
          bad++;
          $display("FAIL stall_stable[c%0d]: got v=%b res=%h tag=%h flags=%b want v=1 res=%h tag=%h flags=%b",
                   cyc, out_valid, out_res, out_tag, out_flags, hold_res, hold_tag, hold_flags);
        end
      end
      out_ready = (cyc <= 8) ? 1'b0 : ($urandom_range(0, 2) != 0);
      in_valid = (sent < 20);
      in_a = ca; in_b = cb; in_op = cop; in_tag = TW'(sent);
      #1;
      total++;
      if (in_ready !== (out_ready | ~out_valid)) begin
        bad++;
        $display("FAIL in_ready[c%0d]: got %b want %b", cyc, in_ready, out_ready | ~out_valid);
      end
      if (cyc == 8) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++; $display("FAIL full_pipe_ready: got in_ready=%b want 0", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL stream_extra[c%0d]: got res=%h with nothing pending", cyc, out_res);
        end else begin
          exp = exp_q.pop_front();
          etag = tag_q.pop_front();
          if ({out_res, out_flags} !== exp || out_tag !== etag) begin
            bad++;
            $display("FAIL stream[%0d]: got res=%h flags=%b tag=%h want res=%h flags=%b tag=%h",
                     got, out_res, out_flags, out_tag, exp[W+3:4], exp[3:0], etag);
          end
        end
        got++;
      end
      stalled = out_valid & ~out_ready;
      hold_res = out_res; hold_tag = out_tag; hold_flags = out_flags;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(ca, cb, cop, 1'b0));
        tag_q.push_back(TW'(sent));
        sent++;
        ca = $urandom; cb = (sent % 6 == 0) ? ca : $urandom; cop = 2'($urandom_range(0, 3));
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    total++;
    if (got != 20 || sent != 20) begin
      bad++; $display("FAIL stream_count: got %0d results of %0d sent want 20", got, sent);
    end
  endtask

  task automatic test_reset_midstream();
    logic [W-1:0] a, b;
    logic [W+3:0] exp;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_op = 2'(i); in_tag = TW'(i + 1);
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL midreset_flush[%0d]: got out_valid=%b tag=%h want 0", i, out_valid, out_tag);
      end
      @(negedge clk);
    end
    a = $urandom; b = $urandom;
    exp = model(a, b, 2'd1, 1'b0);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = 2'd1; in_tag = 4'd7;
    lat = 0;
    do begin
      @(negedge clk); in_valid = 1'b0; lat++;
    end while (!out_valid && lat < 20);
    total++;
    if (lat != S + 1 || {out_res, out_flags} !== exp || out_tag !== 4'd7) begin
      bad++;
      $display("FAIL midreset_next: got lat=%0d res=%h flags=%b tag=%h want lat=%0d res=%h flags=%b tag=7",
               lat, out_res, out_flags, out_tag, S + 1, exp[W+3:4], exp[3:0]);
    end
  endtask

`ifdef ADDSUB_SATURATE_EN
  task automatic test_saturate();
    logic [W-1:0] ta [5] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 32'd0};
    logic [W-1:0] tb [5] = '{32'd1, 32'd1, 32'd1, 32'h8000_0000, 32'h8000_0000};
    logic [1:0]   to [5] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3};
    logic         ts [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] tr [5] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [3:0]   tf [5] = '{4'b0001, 4'b1011, 4'b1001, 4'b1011, 4'b1000};
    logic [W-1:0] a, b;
    logic [1:0] op;
    logic sat;
    logic [W+3:0] exp;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i < 5) begin
        a = ta[i]; b = tb[i]; op = to[i]; sat = ts[i]; exp = {tr[i], tf[i]};
      end else begin
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3)); sat = 1'b1;
        exp = model(a, b, op, sat);
      end
      @(negedge clk);
      in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_sat = sat; in_tag = TW'(i);
      lat = 0;
      do begin
        @(negedge clk); in_valid = 1'b0; in_sat = ~sat; lat++;
      end while (!out_valid && lat < 20);
      in_sat = 1'b0;
      total++;
      if (lat != S + 1 || {out_res, out_flags} !== exp) begin
        bad++;
        $display("FAIL saturate[%0d] op=%0d sat=%b: got lat=%0d res=%h flags=%b want res=%h flags=%b",
                 i, op, sat, lat, out_res, out_flags, exp[W+3:4], exp[3:0]);
      end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
`ifdef ADDSUB_SATURATE_EN
    in_sat = 1'b0;
`endif
    test_reset();
    test_add();
    test_sub_modes();
    test_back_to_back();
    test_reset_midstream();
`ifdef ADDSUB_SATURATE_EN
    test_saturate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
